rtc_timekeeper: RTL and testbench
=================================

# rtc_timekeeper

Parametrised real-time-of-day counter that generalises the team's 24-hour clock block. It derives a one-second tick from the system clock through an internal prescaler and keeps hours/minutes/seconds with a configurable day length. It adds a validated set-time handshake, run/pause control, 12/24-hour display conversion, a single hh:mm alarm and rollover strobes. It sits between the board clock and the display/alarm logic.

## Interface
Parameters:
- `DIV`, 50_000_000, clk cycles per second; legal ≥1; `DIV=1` ticks every cycle.
- `HOURS_PER_DAY`, 24, hour wrap value; legal 2..32.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `run` in 1: 1 = count, 0 = pause; prescaler and time hold.
- `load_valid` in 1: set-time request.
- `load_ready` out 1: block can accept a load.
- `ld_hours` in 5, `ld_minutes` in 6, `ld_seconds` in 6: set-time value.
- `load_err` out 1: one-cycle pulse, load rejected as out of range.
- `alarm_wr` in 1: capture `al_hours` in 5 and `al_minutes` in 6 into the alarm registers.
- `alarm_en` in 1: alarm compare enable.
- `alarm_hit` out 1: one-cycle alarm pulse.
- `mode12` in 1: 12-hour display select.
- `hours` out 5, `minutes` out 6, `seconds` out 6: current time.
- `disp_hours` out 5, `pm` out 1: display hour and PM flag.
- `sec_tick`, `min_tick`, `hour_tick`, `day_tick` out 1 each: rollover strobes.

## Operation
- Reset (`reset`=0): time, prescaler, alarm registers and all pulses go to 0. `load_ready`=0 while `reset`=0 and in the first cycle after release, then 1.
- Prescaler `pcnt` counts 0..DIV-1 only while `run`=1. A tick event occurs in the cycle where `run`=1 and `pcnt`=DIV-1; `pcnt` then returns to 0.
- Tick: `seconds` goes 0..59 and wraps to 0. On a seconds wrap, `minutes` increments (0..59). On a minutes wrap, `hours` increments, 0..HOURS_PER_DAY-1, wrapping to 0.
- Strobes: `sec_tick` fires on every tick. `min_tick` fires on a seconds wrap, `hour_tick` on a minutes wrap, `day_tick` on an hours wrap. Each strobe is high exactly for the cycle in which the new value is first visible.
- Load handshake: accepted when `load_valid` && `load_ready`. If `ld_hours`<HOURS_PER_DAY, `ld_minutes`<60 and `ld_seconds`<60, the time is replaced and `pcnt` is cleared. Otherwise the time is unchanged and `load_err` pulses. `load_ready` drops for exactly the one cycle after any accept. `load_valid` while `load_ready`=0 is ignored and has no side effects.
- Load vs tick in the same cycle: the load wins, the tick is discarded and no strobes fire. A rejected load does not suppress a tick.
- Alarm: `alarm_hit` pulses when a tick produces `seconds`=0 with `hours`/`minutes` equal to the alarm registers and `alarm_en`=1. Loads never raise `alarm_hit`. If `alarm_wr` occurs in the same cycle as the tick, the compare uses the old alarm values.
- Display, combinational from registered time:
  - If `mode12`=0 or HOURS_PER_DAY≠24: `disp_hours`=`hours`, `pm`=0.
  - Otherwise: hour 0 → 12 AM, 1..11 → AM, 12 → 12 PM, 13..23 → `hours`-12 with PM.
- Control FSM with states STOP and RUN: STOP→RUN when `run`=1, RUN→STOP when `run`=0. The transition takes effect in the same cycle; no tick occurs in STOP. Loads are accepted in both states.

## Timing
- All outputs except `disp_hours`/`pm` are registered. Time, strobes and `alarm_hit` update on the clock edge ending the tick cycle, a latency of 1.
- A load is visible 1 cycle after acceptance. The first tick after a load follows DIV running cycles later.
- Pausing preserves `pcnt`, so resume continues the partial second.
- When `reset` is asserted mid-second or mid-load, the reset result overrides everything in that cycle.

## Test plan
- DIV=4: release reset and hold `run`=1 → `seconds` increments every 4 cycles and `sec_tick` is high with each new value. `load_ready` rises 1 cycle after release.
- Load 23:59:58, run 2 ticks → 23:59:59, then 00:00:00. On the second tick `sec_tick`, `min_tick`, `hour_tick` and `day_tick` all pulse together.
- HOURS_PER_DAY=12: load 11:59:59 and tick → 00:00:00 with `day_tick`. Load `ld_hours`=12 → `load_err` pulses and the time is unchanged.
- Alarm 07:30 with `alarm_en`=1, load 07:29:59 and tick → 07:30:00 with `alarm_hit`=1 for one cycle. Loading 07:30:00 directly gives `alarm_hit`=0.
- Assert `load_valid` in the same cycle as a tick → the loaded value appears and no strobe fires. `load_ready` is 0 for the next cycle.
- `mode12`=1: `hours`=0 → 12/`pm`=0, `hours`=12 → 12/`pm`=1, `hours`=15 → 3/`pm`=1. With `run`=0 for 10 cycles, time and `pcnt` are held, and after resume the tick lands after the remaining cycles.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: real-time-of-day counter with a cycle prescaler, set-time
// handshake with range validation, run/pause control, a single hh:mm alarm,
// 12/24-hour display conversion and rollover strobes.
module rtc_timekeeper #(
  parameter int DIV           = 50_000_000,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [4:0] ld_hours,
  input  logic [5:0] ld_minutes,
  input  logic [5:0] ld_seconds,
  output logic       load_err,
  input  logic       alarm_wr,
  input  logic [4:0] al_hours,
  input  logic [5:0] al_minutes,
  input  logic       alarm_en,
  output logic       alarm_hit,
  input  logic       mode12,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] disp_hours,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick
);

  localparam int             PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PLAST = PW'(DIV - 1);
  localparam logic [4:0]     HLAST = 5'(HOURS_PER_DAY - 1);
  localparam logic [5:0]     HLIM  = 6'(HOURS_PER_DAY);
  localparam bit             IS24  = (HOURS_PER_DAY == 24);

  typedef enum logic {ST_STOP, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
  logic [4:0]    al_hours_q, al_hours_d;
  logic [5:0]    al_minutes_q, al_minutes_d;
  logic          load_ready_q, load_ready_d;
  logic          load_err_q, load_err_d;
  logic          alarm_hit_q, alarm_hit_d;
  logic          sec_tick_q, sec_tick_d;
  logic          min_tick_q, min_tick_d;
  logic          hour_tick_q, hour_tick_d;
  logic          day_tick_q, day_tick_d;

  logic          counting;
  logic          tick, load_acc, load_ok, load_take, do_tick;
  logic          sec_wrap, min_wrap, hour_wrap;
  logic [4:0]    nxt_hours;
  logic [5:0]    nxt_minutes, nxt_seconds;

  // Run/stop control: a state change counts in the same cycle it is requested.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    counting = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (run) begin
          state_d  = ST_RUN;
          counting = 1'b1;
        end
      end
      ST_RUN: begin
        if (run) counting = 1'b1;
        else     state_d  = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Tick, load arbitration and the incremented time candidate.
  always_comb begin
    tick      = counting && (pcnt_q == PLAST);
    load_acc  = load_valid && load_ready_q;
    load_ok   = ({1'b0, ld_hours} < HLIM) && (ld_minutes < 6'd60) && (ld_seconds < 6'd60);
    load_take = load_acc && load_ok;
    // A valid load overrides the tick; a rejected one leaves it alone.
    do_tick   = tick && !load_take;

    sec_wrap  = (seconds_q == 6'd59);
    min_wrap  = sec_wrap && (minutes_q == 6'd59);
    hour_wrap = min_wrap && (hours_q == HLAST);

    nxt_seconds = sec_wrap ? 6'd0 : seconds_q + 6'd1;
    nxt_minutes = minutes_q;
    if (sec_wrap) nxt_minutes = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
    nxt_hours = hours_q;
    if (min_wrap) nxt_hours = hour_wrap ? 5'd0 : hours_q + 5'd1;
  end

  // Next-state for prescaler, time, alarm registers and registered pulses.
  always_comb begin
    pcnt_d = pcnt_q;
    if (load_take)     pcnt_d = '0;
    else if (counting) pcnt_d = tick ? '0 : pcnt_q + PW'(1);

    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    if (load_take) begin
      hours_d   = ld_hours;
      minutes_d = ld_minutes;
      seconds_d = ld_seconds;
    end else if (do_tick) begin
      hours_d   = nxt_hours;
      minutes_d = nxt_minutes;
      seconds_d = nxt_seconds;
    end

    al_hours_d   = alarm_wr ? al_hours   : al_hours_q;
    al_minutes_d = alarm_wr ? al_minutes : al_minutes_q;

    load_ready_d = !load_acc;
    load_err_d   = load_acc && !load_ok;

    sec_tick_d  = do_tick;
    min_tick_d  = do_tick && sec_wrap;
    hour_tick_d = do_tick && min_wrap;
    day_tick_d  = do_tick && hour_wrap;

    // Compare against the alarm registers as they stand before any write.
    alarm_hit_d = do_tick && alarm_en && (nxt_seconds == 6'd0) &&
                  (nxt_hours == al_hours_q) && (nxt_minutes == al_minutes_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!reset) begin
      state_q      <= ST_STOP;
      pcnt_q       <= '0;
      hours_q      <= '0;
      minutes_q    <= '0;
      seconds_q    <= '0;
      al_hours_q   <= '0;
      al_minutes_q <= '0;
      load_ready_q <= 1'b0;
      load_err_q   <= 1'b0;
      alarm_hit_q  <= 1'b0;
      sec_tick_q   <= 1'b0;
      min_tick_q   <= 1'b0;
      hour_tick_q  <= 1'b0;
      day_tick_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      al_hours_q   <= al_hours_d;
      al_minutes_q <= al_minutes_d;
      load_ready_q <= load_ready_d;
      load_err_q   <= load_err_d;
      alarm_hit_q  <= alarm_hit_d;
      sec_tick_q   <= sec_tick_d;
      min_tick_q   <= min_tick_d;
      hour_tick_q  <= hour_tick_d;
      day_tick_q   <= day_tick_d;
    end
  end

  // 12-hour display conversion, only meaningful for a 24-hour day.
  always_comb begin
    disp_hours = hours_q;
    pm         = 1'b0;
    if (mode12 && IS24) begin
      if (hours_q == 5'd0) begin
        disp_hours = 5'd12;
      end else if (hours_q >= 5'd12) begin
        pm = 1'b1;
        if (hours_q > 5'd12) disp_hours = hours_q - 5'd12;
      end
    end
  end

  assign load_ready = load_ready_q;
  assign load_err   = load_err_q;
  assign alarm_hit  = alarm_hit_q;
  assign hours      = hours_q;
  assign minutes    = minutes_q;
  assign seconds    = seconds_q;
  assign sec_tick   = sec_tick_q;
  assign min_tick   = min_tick_q;
  assign hour_tick  = hour_tick_q;
  assign day_tick   = day_tick_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper: a 24-hour instance and a 12-hour
// instance, both with DIV=4, share one stimulus stream.
module tb_rtc_timekeeper;

  logic       clk = 1'b0;
  logic       reset, run, load_valid, alarm_wr, alarm_en, mode12;
  logic [4:0] ld_hours, al_hours;
  logic [5:0] ld_minutes, ld_seconds, al_minutes;

  logic       a_load_ready, a_load_err, a_alarm_hit, a_pm;
  logic [4:0] a_hours, a_disp_hours;
  logic [5:0] a_minutes, a_seconds;
  logic       a_sec_tick, a_min_tick, a_hour_tick, a_day_tick;

  logic       b_load_ready, b_load_err, b_alarm_hit, b_pm;
  logic [4:0] b_hours, b_disp_hours;
  logic [5:0] b_minutes, b_seconds;
  logic       b_sec_tick, b_min_tick, b_hour_tick, b_day_tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rtc_timekeeper #(.DIV(4), .HOURS_PER_DAY(24)) u_a (
    .clk(clk), .reset(reset), .run(run),
    .load_valid(load_valid), .load_ready(a_load_ready),
    .ld_hours(ld_hours), .ld_minutes(ld_minutes), .ld_seconds(ld_seconds),
    .load_err(a_load_err), .alarm_wr(alarm_wr), .al_hours(al_hours),
    .al_minutes(al_minutes), .alarm_en(alarm_en), .alarm_hit(a_alarm_hit),
    .mode12(mode12), .hours(a_hours), .minutes(a_minutes), .seconds(a_seconds),
    .disp_hours(a_disp_hours), .pm(a_pm), .sec_tick(a_sec_tick),
    .min_tick(a_min_tick), .hour_tick(a_hour_tick), .day_tick(a_day_tick)
  );

  rtc_timekeeper #(.DIV(4), .HOURS_PER_DAY(12)) u_b (
    .clk(clk), .reset(reset), .run(run),
    .load_valid(load_valid), .load_ready(b_load_ready),
    .ld_hours(ld_hours), .ld_minutes(ld_minutes), .ld_seconds(ld_seconds),
    .load_err(b_load_err), .alarm_wr(alarm_wr), .al_hours(al_hours),
    .al_minutes(al_minutes), .alarm_en(alarm_en), .alarm_hit(b_alarm_hit),
    .mode12(mode12), .hours(b_hours), .minutes(b_minutes), .seconds(b_seconds),
    .disp_hours(b_disp_hours), .pm(b_pm), .sec_tick(b_sec_tick),
    .min_tick(b_min_tick), .hour_tick(b_hour_tick), .day_tick(b_day_tick)
  );

  // Advance one clock and settle just after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a load request for exactly one clock.
  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    ld_hours   = h;
    ld_minutes = m;
    ld_seconds = s;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run   = 1'b1;
    step(3);
    total++;
    if ({a_hours, a_minutes, a_seconds} !== 17'd0) begin
      bad++; $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", a_hours, a_minutes, a_seconds);
    end
    total++;
    if ({a_load_ready, a_load_err, a_alarm_hit, a_sec_tick, a_min_tick, a_hour_tick, a_day_tick} !== 7'd0) begin
      bad++; $display("FAIL reset_flags: got ready=%b err=%b hit=%b ticks=%b%b%b%b want all 0",
                      a_load_ready, a_load_err, a_alarm_hit, a_sec_tick, a_min_tick, a_hour_tick, a_day_tick);
    end
    run   = 1'b0;
    reset = 1'b1;
    total++;
    if (a_load_ready !== 1'b0) begin
      bad++; $display("FAIL ready_first_cycle: got %b want 0", a_load_ready);
    end
    step();
    total++;
    if (a_load_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_release: got %b want 1", a_load_ready);
    end
  endtask

  task automatic test_count();
    run = 1'b1;
    step(3);
    total++;
    if (a_seconds !== 6'd0 || a_sec_tick !== 1'b0) begin
      bad++; $display("FAIL count_pre: got sec=%0d tick=%b want 0/0", a_seconds, a_sec_tick);
    end
    step();
    total++;
    if (a_seconds !== 6'd1 || a_sec_tick !== 1'b1) begin
      bad++; $display("FAIL count_first: got sec=%0d tick=%b want 1/1", a_seconds, a_sec_tick);
    end
    step();
    total++;
    if (a_sec_tick !== 1'b0) begin
      bad++; $display("FAIL count_tick_drop: got %b want 0", a_sec_tick);
    end
    step(3);
    total++;
    if (a_seconds !== 6'd2 || a_sec_tick !== 1'b1) begin
      bad++; $display("FAIL count_second: got sec=%0d tick=%b want 2/1", a_seconds, a_sec_tick);
    end
  endtask

  task automatic test_rollover();
    do_load(5'd23, 6'd59, 6'd58);
    total++;
    if ({a_hours, a_minutes, a_seconds} !== {5'd23, 6'd59, 6'd58} || a_load_ready !== 1'b0) begin
      bad++; $display("FAIL roll_load: got %0d:%0d:%0d ready=%b want 23:59:58 ready=0",
                      a_hours, a_minutes, a_seconds, a_load_ready);
    end
    step(4);
    total++;
    if ({a_hours, a_minutes, a_seconds} !== {5'd23, 6'd59, 6'd59} ||
        {a_sec_tick, a_min_tick, a_hour_tick, a_day_tick} !== 4'b1000) begin
      bad++; $display("FAIL roll_tick1: got %0d:%0d:%0d strobes=%b%b%b%b want 23:59:59 1000",
                      a_hours, a_minutes, a_seconds, a_sec_tick, a_min_tick, a_hour_tick, a_day_tick);
    end
    step(4);
    total++;
    if ({a_hours, a_minutes, a_seconds} !== 17'd0 ||
        {a_sec_tick, a_min_tick, a_hour_tick, a_day_tick} !== 4'b1111) begin
      bad++; $display("FAIL roll_tick2: got %0d:%0d:%0d strobes=%b%b%b%b want 0:0:0 1111",
                      a_hours, a_minutes, a_seconds, a_sec_tick, a_min_tick, a_hour_tick, a_day_tick);
    end
    step();
    total++;
    if ({a_sec_tick, a_min_tick, a_hour_tick, a_day_tick} !== 4'b0000) begin
      bad++; $display("FAIL roll_strobe_drop: got %b%b%b%b want 0000",
                      a_sec_tick, a_min_tick, a_hour_tick, a_day_tick);
    end
  endtask

  task automatic test_hpd12();
    do_load(5'd11, 6'd59, 6'd59);
    step(4);
    total++;
    if ({b_hours, b_minutes, b_seconds} !== 17'd0 || b_day_tick !== 1'b1 || b_hour_tick !== 1'b1) begin
      bad++; $display("FAIL h12_wrap: got %0d:%0d:%0d day=%b hour=%b want 0:0:0 1 1",
                      b_hours, b_minutes, b_seconds, b_day_tick, b_hour_tick);
    end
    total++;
    if ({a_hours, a_minutes, a_seconds} !== {5'd12, 6'd0, 6'd0} || a_day_tick !== 1'b0 || a_hour_tick !== 1'b1) begin
      bad++; $display("FAIL h24_noon: got %0d:%0d:%0d day=%b hour=%b want 12:0:0 0 1",
                      a_hours, a_minutes, a_seconds, a_day_tick, a_hour_tick);
    end
    run = 1'b0;
    do_load(5'd12, 6'd0, 6'd0);
    total++;
    if (b_load_err !== 1'b1 || {b_hours, b_minutes, b_seconds} !== 17'd0 || b_load_ready !== 1'b0) begin
      bad++; $display("FAIL h12_reject: got err=%b %0d:%0d:%0d ready=%b want 1 0:0:0 0",
                      b_load_err, b_hours, b_minutes, b_seconds, b_load_ready);
    end
    total++;
    if (a_load_err !== 1'b0) begin
      bad++; $display("FAIL h24_accept_err: got %b want 0", a_load_err);
    end
    step();
    total++;
    if (b_load_err !== 1'b0) begin
      bad++; $display("FAIL h12_err_pulse: got %b want 0", b_load_err);
    end
  endtask

  task automatic test_alarm();
    run        = 1'b0;
    al_hours   = 5'd7;
    al_minutes = 6'd30;
    alarm_wr   = 1'b1;
    alarm_en   = 1'b1;
    step();
    alarm_wr = 1'b0;
    do_load(5'd7, 6'd29, 6'd59);
    run = 1'b1;
    step(3);
    total++;
    if (a_alarm_hit !== 1'b0 || {a_hours, a_minutes, a_seconds} !== {5'd7, 6'd29, 6'd59}) begin
      bad++; $display("FAIL alarm_early: got hit=%b %0d:%0d:%0d want 0 7:29:59",
                      a_alarm_hit, a_hours, a_minutes, a_seconds);
    end
    step();
    total++;
    if (a_alarm_hit !== 1'b1 || {a_hours, a_minutes, a_seconds} !== {5'd7, 6'd30, 6'd0}) begin
      bad++; $display("FAIL alarm_hit: got hit=%b %0d:%0d:%0d want 1 7:30:0",
                      a_alarm_hit, a_hours, a_minutes, a_seconds);
    end
    step();
    total++;
    if (a_alarm_hit !== 1'b0) begin
      bad++; $display("FAIL alarm_pulse: got %b want 0", a_alarm_hit);
    end
    run = 1'b0;
    do_load(5'd7, 6'd30, 6'd0);
    total++;
    if (a_alarm_hit !== 1'b0 || {a_hours, a_minutes, a_seconds} !== {5'd7, 6'd30, 6'd0}) begin
      bad++; $display("FAIL alarm_on_load: got hit=%b %0d:%0d:%0d want 0 7:30:0",
                      a_alarm_hit, a_hours, a_minutes, a_seconds);
    end
    step();
  endtask

  task automatic test_back_to_back();
    run = 1'b1;
    step(3);
    ld_hours   = 5'd1;
    ld_minutes = 6'd2;
    ld_seconds = 6'd3;
    load_valid = 1'b1;
    step();
    total++;
    if ({a_hours, a_minutes, a_seconds} !== {5'd1, 6'd2, 6'd3} || a_sec_tick !== 1'b0 || a_load_ready !== 1'b0) begin
      bad++; $display("FAIL load_vs_tick: got %0d:%0d:%0d tick=%b ready=%b want 1:2:3 0 0",
                      a_hours, a_minutes, a_seconds, a_sec_tick, a_load_ready);
    end
    ld_hours   = 5'd4;
    ld_minutes = 6'd5;
    ld_seconds = 6'd6;
    step();
    load_valid = 1'b0;
    total++;
    if ({a_hours, a_minutes, a_seconds} !== {5'd1, 6'd2, 6'd3} || a_load_ready !== 1'b1 || a_load_err !== 1'b0) begin
      bad++; $display("FAIL load_not_ready: got %0d:%0d:%0d ready=%b err=%b want 1:2:3 1 0",
                      a_hours, a_minutes, a_seconds, a_load_ready, a_load_err);
    end
    step(3);
    total++;
    if ({a_hours, a_minutes, a_seconds} !== {5'd1, 6'd2, 6'd4} || a_sec_tick !== 1'b1) begin
      bad++; $display("FAIL tick_after_load: got %0d:%0d:%0d tick=%b want 1:2:4 1",
                      a_hours, a_minutes, a_seconds, a_sec_tick);
    end
  endtask

  task automatic test_display();
    run    = 1'b0;
    mode12 = 1'b1;
    do_load(5'd0, 6'd0, 6'd0);
    total++;
    if (a_disp_hours !== 5'd12 || a_pm !== 1'b0) begin
      bad++; $display("FAIL disp_midnight: got %0d pm=%b want 12 0", a_disp_hours, a_pm);
    end
    total++;
    if (b_disp_hours !== 5'd0 || b_pm !== 1'b0) begin
      bad++; $display("FAIL disp_h12_passthru: got %0d pm=%b want 0 0", b_disp_hours, b_pm);
    end
    step();
    do_load(5'd12, 6'd0, 6'd0);
    total++;
    if (a_disp_hours !== 5'd12 || a_pm !== 1'b1) begin
      bad++; $display("FAIL disp_noon: got %0d pm=%b want 12 1", a_disp_hours, a_pm);
    end
    step();
    do_load(5'd15, 6'd0, 6'd0);
    total++;
    if (a_disp_hours !== 5'd3 || a_pm !== 1'b1) begin
      bad++; $display("FAIL disp_15: got %0d pm=%b want 3 1", a_disp_hours, a_pm);
    end
    mode12 = 1'b0;
    #1;
    total++;
    if (a_disp_hours !== 5'd15 || a_pm !== 1'b0) begin
      bad++; $display("FAIL disp_24mode: got %0d pm=%b want 15 0", a_disp_hours, a_pm);
    end
    mode12 = 1'b1;
    step();
    do_load(5'd5, 6'd0, 6'd0);
    total++;
    if (a_disp_hours !== 5'd5 || a_pm !== 1'b0) begin
      bad++; $display("FAIL disp_5am: got %0d pm=%b want 5 0", a_disp_hours, a_pm);
    end
  endtask

  task automatic test_pause();
    run = 1'b1;
    step(2);
    run = 1'b0;
    step(10);
    total++;
    if ({a_hours, a_minutes, a_seconds} !== {5'd5, 6'd0, 6'd0} || a_sec_tick !== 1'b0) begin
      bad++; $display("FAIL pause_hold: got %0d:%0d:%0d tick=%b want 5:0:0 0",
                      a_hours, a_minutes, a_seconds, a_sec_tick);
    end
    run = 1'b1;
    step();
    total++;
    if (a_seconds !== 6'd0) begin
      bad++; $display("FAIL resume_early: got sec=%0d want 0", a_seconds);
    end
    step();
    total++;
    if (a_seconds !== 6'd1 || a_sec_tick !== 1'b1) begin
      bad++; $display("FAIL resume_tick: got sec=%0d tick=%b want 1 1", a_seconds, a_sec_tick);
    end
  endtask

  task automatic test_reset_mid();
    step(2);
    ld_hours   = 5'd6;
    ld_minutes = 6'd6;
    ld_seconds = 6'd6;
    load_valid = 1'b1;
    reset      = 1'b0;
    step();
    load_valid = 1'b0;
    total++;
    if ({a_hours, a_minutes, a_seconds} !== 17'd0 || a_load_ready !== 1'b0 || a_sec_tick !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got %0d:%0d:%0d ready=%b tick=%b want 0:0:0 0 0",
                      a_hours, a_minutes, a_seconds, a_load_ready, a_sec_tick);
    end
    reset = 1'b1;
    step(4);
    total++;
    if (a_seconds !== 6'd1) begin
      bad++; $display("FAIL reset_mid_restart: got sec=%0d want 1", a_seconds);
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; load_valid = 1'b0; alarm_wr = 1'b0;
    alarm_en = 1'b0; mode12 = 1'b0;
    ld_hours = '0; ld_minutes = '0; ld_seconds = '0;
    al_hours = '0; al_minutes = '0;
    test_reset();
    test_count();
    test_rollover();
    test_hpd12();
    test_alarm();
    test_back_to_back();
    test_display();
    test_pause();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
